// File: rtl/motor_drive_controller.sv
// Dual H-bridge drive for the line tracker: maps the steering command to per-wheel
// direction/duty targets and slews each wheel's duty with a tick-driven ramp.
module motor_drive_controller #(
   parameter int PWM_BITS  = 10,
   parameter int DUTY_FAST = 1023,
   parameter int DUTY_SLOW = 512,
   parameter int RAMP_DIV  = 50000,
   parameter int RAMP_STEP = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] state,
   output logic       left_pwm,
   output logic       right_pwm,
   output logic [1:0] left_dir,
   output logic [1:0] right_dir,
   output logic       moving
);

   localparam int W        = PWM_BITS + 1;
   localparam int PRE_BITS = $clog2(RAMP_DIV);
   localparam int MAX_DUTY = (1 << PWM_BITS) - 1;

   localparam logic [PRE_BITS-1:0] PRE_LAST = PRE_BITS'(RAMP_DIV - 1);
   localparam logic [W-1:0] STEP = W'(RAMP_STEP);
   localparam logic [W-1:0] FAST = W'((DUTY_FAST > MAX_DUTY) ? MAX_DUTY : DUTY_FAST);
   localparam logic [W-1:0] SLOW = W'((DUTY_SLOW > MAX_DUTY) ? MAX_DUTY : DUTY_SLOW);

   localparam logic [1:0] DIR_FWD   = 2'b10;
   localparam logic [1:0] DIR_REV   = 2'b01;
   localparam logic [1:0] DIR_COAST = 2'b00;

   typedef enum logic [2:0] {
      CMD_TURN_LEFT   = 3'b000,
      CMD_TURN_RIGHT  = 3'b001,
      CMD_STRAIGHT    = 3'b010,
      CMD_STOP        = 3'b011,
      CMD_SHARP_LEFT  = 3'b100,
      CMD_SHARP_RIGHT = 3'b101
   } cmd_e;

   typedef struct packed {
      logic [1:0]   dir;
      logic [W-1:0] duty;
   } motor_t;

   logic [2:0]          state_q;
   logic [PRE_BITS-1:0] prescaler;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                tick;
   logic                stop_cmd;
   motor_t              left_m, right_m;
   motor_t              left_tgt, right_tgt;
   logic [W-1:0]        left_duty, right_duty;

   // One motor's ramp step: a wrong direction is first ramped to zero, then flipped,
   // so the H-bridge pins can never change under load.
   function automatic motor_t ramp_next(input motor_t cur, input motor_t tgt);
      motor_t       nxt;
      logic [W:0]   up;
      logic [W-1:0] down;
      nxt  = cur;
      up   = {1'b0, cur.duty} + {1'b0, STEP};
      down = (cur.duty > STEP) ? (cur.duty - STEP) : '0;
      if (cur.dir != tgt.dir) begin
         if (cur.duty != '0)
            nxt.duty = down;
         else
            nxt.dir = tgt.dir;
      end else if (cur.duty < tgt.duty) begin
         nxt.duty = (up > {1'b0, tgt.duty}) ? tgt.duty : up[W-1:0];
      end else if (cur.duty > tgt.duty) begin
         nxt.duty = (down < tgt.duty) ? tgt.duty : down;
      end
      return nxt;
   endfunction

   assign tick = (prescaler == PRE_LAST);

   // Command decode; anything not explicitly a motion command is treated as stop.
   always_comb begin
      left_tgt  = '{dir: DIR_COAST, duty: '0};
      right_tgt = '{dir: DIR_COAST, duty: '0};
      stop_cmd  = 1'b0;
      case (state_q)
         CMD_STRAIGHT: begin
            left_tgt  = '{dir: DIR_FWD, duty: FAST};
            right_tgt = '{dir: DIR_FWD, duty: FAST};
         end
         CMD_TURN_LEFT: begin
            left_tgt  = '{dir: DIR_FWD, duty: SLOW};
            right_tgt = '{dir: DIR_FWD, duty: FAST};
         end
         CMD_TURN_RIGHT: begin
            left_tgt  = '{dir: DIR_FWD, duty: FAST};
            right_tgt = '{dir: DIR_FWD, duty: SLOW};
         end
         CMD_SHARP_LEFT: begin
            left_tgt  = '{dir: DIR_REV, duty: SLOW};
            right_tgt = '{dir: DIR_FWD, duty: FAST};
         end
         CMD_SHARP_RIGHT: begin
            left_tgt  = '{dir: DIR_FWD, duty: FAST};
            right_tgt = '{dir: DIR_REV, duty: SLOW};
         end
         CMD_STOP: stop_cmd = 1'b1;
         default:  stop_cmd = 1'b1;
      endcase
   end

   // Stop acts every cycle and beats a coincident tick; motion only changes on ticks.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= CMD_STOP;
         prescaler <= '0;
         pwm_cnt   <= '0;
         left_m    <= '0;
         right_m   <= '0;
         left_pwm  <= 1'b0;
         right_pwm <= 1'b0;
         moving    <= 1'b0;
      end else begin
         state_q   <= state;
         prescaler <= tick ? '0 : prescaler + 1'b1;
         pwm_cnt   <= pwm_cnt + 1'b1;
         if (stop_cmd) begin
            left_m  <= '0;
            right_m <= '0;
         end else if (tick) begin
            left_m  <= ramp_next(left_m, left_tgt);
            right_m <= ramp_next(right_m, right_tgt);
         end
         left_pwm  <= ({1'b0, pwm_cnt} < left_m.duty);
         right_pwm <= ({1'b0, pwm_cnt} < right_m.duty);
         moving    <= (left_m.duty != '0) || (right_m.duty != '0);
      end
   end

   assign left_dir   = left_m.dir;
   assign right_dir  = right_m.dir;
   assign left_duty  = left_m.duty;
   assign right_duty = right_m.duty;

endmodule

// File: tb/tb_motor_drive_controller.sv
// Scoreboard bench for motor_drive_controller: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them as the cycles arrive.
module tb_motor_drive_controller;

   localparam int PWM_BITS  = 10;
   localparam int RAMP_DIV  = 4;
   localparam int RAMP_STEP = 256;
   localparam int DUTY_FAST = 1023;
   localparam int DUTY_SLOW = 512;

   localparam logic [1:0] FWD   = 2'b10;
   localparam logic [1:0] REV   = 2'b01;
   localparam logic [1:0] COAST = 2'b00;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] state = 3'b011;
   logic       left_pwm, right_pwm, moving;
   logic [1:0] left_dir, right_dir;

   motor_drive_controller #(
      .PWM_BITS (PWM_BITS),
      .DUTY_FAST(DUTY_FAST),
      .DUTY_SLOW(DUTY_SLOW),
      .RAMP_DIV (RAMP_DIV),
      .RAMP_STEP(RAMP_STEP)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .state    (state),
      .left_pwm (left_pwm),
      .right_pwm(right_pwm),
      .left_dir (left_dir),
      .right_dir(right_dir),
      .moving   (moving)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum int {K_STATE, K_OUT, K_MOV, K_WSTART, K_WEND} kind_e;

   typedef struct {
      int         cyc;
      kind_e      kind;
      string      name;
      logic [1:0] ldir;
      logic [1:0] rdir;
      int         lval;
      int         rval;
      logic       lpwm;
      logic       rpwm;
      logic       mov;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   rel_edge = 0;
   logic win_on = 1'b0;
   int   win_l = 0;
   int   win_r = 0;

   // First ramp-tick edge strictly after the given edge, counted from reset release.
   function automatic int next_tick(input int after);
      int e;
      e = after + 1;
      while ((e - rel_edge) % RAMP_DIV != 0) e++;
      return e;
   endfunction

   function automatic exp_t blank(input int c, input kind_e k, input string n);
      exp_t e;
      e.cyc = c; e.kind = k; e.name = n;
      e.ldir = COAST; e.rdir = COAST; e.lval = 0; e.rval = 0;
      e.lpwm = 1'b0; e.rpwm = 1'b0; e.mov = 1'b0;
      return e;
   endfunction

   task automatic push_state(input int c, input string n, input logic [1:0] ld,
                             input logic [1:0] rd, input int lu, input int ru);
      exp_t e;
      e = blank(c, K_STATE, n);
      e.ldir = ld; e.rdir = rd; e.lval = lu; e.rval = ru;
      sb.push_back(e);
   endtask

   task automatic push_out(input int c, input string n, input logic lp, input logic rp,
                           input logic mv);
      exp_t e;
      e = blank(c, K_OUT, n);
      e.lpwm = lp; e.rpwm = rp; e.mov = mv;
      sb.push_back(e);
   endtask

   task automatic push_mov(input int c, input string n, input logic mv);
      exp_t e;
      e = blank(c, K_MOV, n);
      e.mov = mv;
      sb.push_back(e);
   endtask

   task automatic push_window(input int s, input int len, input int lexp, input int rexp);
      exp_t e;
      e = blank(s, K_WSTART, "pwm_window_start");
      sb.push_back(e);
      e = blank(s + len, K_WEND, "pwm_window_count");
      e.lval = lexp; e.rval = rexp;
      sb.push_back(e);
   endtask

   task automatic check_output(input exp_t e);
      case (e.kind)
         K_STATE: begin
            vectors++;
            if (left_dir !== e.ldir || right_dir !== e.rdir ||
                int'(dut.left_duty) != e.lval || int'(dut.right_duty) != e.rval) begin
               miscompares++;
               $display("[TB] FAIL %s @%0d: got ldir=%b rdir=%b lduty=%0d rduty=%0d, want ldir=%b rdir=%b lduty=%0d rduty=%0d",
                        e.name, cyc, left_dir, right_dir, dut.left_duty, dut.right_duty,
                        e.ldir, e.rdir, e.lval, e.rval);
            end
         end
         K_OUT: begin
            vectors++;
            if (left_pwm !== e.lpwm || right_pwm !== e.rpwm || moving !== e.mov) begin
               miscompares++;
               $display("[TB] FAIL %s @%0d: got lpwm=%b rpwm=%b moving=%b, want lpwm=%b rpwm=%b moving=%b",
                        e.name, cyc, left_pwm, right_pwm, moving, e.lpwm, e.rpwm, e.mov);
            end
         end
         K_MOV: begin
            vectors++;
            if (moving !== e.mov) begin
               miscompares++;
               $display("[TB] FAIL %s @%0d: got moving=%b, want %b", e.name, cyc, moving, e.mov);
            end
         end
         K_WSTART: begin
            win_on = 1'b1;
            win_l  = 0;
            win_r  = 0;
         end
         K_WEND: begin
            win_on = 1'b0;
            vectors++;
            if (win_l != e.lval || win_r != e.rval) begin
               miscompares++;
               $display("[TB] FAIL %s @%0d: got high counts l=%0d r=%0d, want l=%0d r=%0d",
                        e.name, cyc, win_l, win_r, e.lval, e.rval);
            end
         end
         default: ;
      endcase
   endtask

   logic [1:0] prev_ldir = COAST, prev_rdir = COAST;
   int         prev_lduty = 0, prev_rduty = 0;
   logic       prev_reset = 1'b1;

   // Monitor: services due scoreboard entries, accumulates PWM windows and
   // watches that a wheel only picks a new direction while standing still.
   always @(negedge clk) begin : monitor
      int i;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].cyc == cyc) begin
            check_output(sb[i]);
            sb.delete(i);
         end else if (sb[i].cyc < cyc) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s: expectation for cycle %0d not serviced (now %0d)",
                     sb[i].name, sb[i].cyc, cyc);
            sb.delete(i);
         end else begin
            i++;
         end
      end
      if (win_on) begin
         win_l += int'(left_pwm);
         win_r += int'(right_pwm);
      end
      if (!prev_reset && left_dir != prev_ldir && left_dir != COAST) begin
         vectors++;
         if (prev_lduty != 0) begin
            miscompares++;
            $display("[TB] FAIL left_dir_flip @%0d: dir %b->%b with duty %0d, want duty 0",
                     cyc, prev_ldir, left_dir, prev_lduty);
         end
      end
      if (!prev_reset && right_dir != prev_rdir && right_dir != COAST) begin
         vectors++;
         if (prev_rduty != 0) begin
            miscompares++;
            $display("[TB] FAIL right_dir_flip @%0d: dir %b->%b with duty %0d, want duty 0",
                     cyc, prev_rdir, right_dir, prev_rduty);
         end
      end
      prev_ldir  = left_dir;
      prev_rdir  = right_dir;
      prev_lduty = int'(dut.left_duty);
      prev_rduty = int'(dut.right_duty);
      prev_reset = reset;
   end

   task automatic apply_stimulus(input logic [2:0] cmd);
      state = cmd;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin : stimulus
      int t, s, ws, guard;
      int ramp_up[4]   = '{256, 512, 768, 1023};
      int rev_duty[8]  = '{767, 511, 255, 0, 0, 256, 512, 512};
      logic [1:0] rev_dir[8] = '{FWD, FWD, FWD, FWD, REV, REV, REV, REV};

      reset = 1'b1;
      apply_stimulus(3'b011);
      wait_until(2);
      rel_edge = cyc;
      push_state(cyc, "reset_state", COAST, COAST, 0, 0);
      push_out(cyc, "reset_out", 1'b0, 1'b0, 1'b0);

      // go_straight from rest: one tick for direction, then four ramp ticks
      reset = 1'b0;
      apply_stimulus(3'b010);
      t = next_tick(cyc + 1);
      push_state(t, "straight_dir", FWD, FWD, 0, 0);
      push_mov(t + 1, "straight_idle", 1'b0);
      for (int k = 0; k < 4; k++)
         push_state(t + 4 * (k + 1), "straight_ramp", FWD, FWD, ramp_up[k], ramp_up[k]);
      push_mov(t + 5, "straight_moving", 1'b1);
      wait_until(t + 16);
      ws = cyc + 4;
      push_window(ws, 1024, 1023, 1023);
      wait_until(ws + 1024);

      // turn_left from full speed
      apply_stimulus(3'b000);
      t = next_tick(cyc + 1);
      push_state(t, "turn_left_1", FWD, FWD, 767, 1023);
      push_state(t + 1, "turn_left_hold", FWD, FWD, 767, 1023);
      push_state(t + 4, "turn_left_2", FWD, FWD, 512, 1023);
      push_state(t + 8, "turn_left_settled", FWD, FWD, 512, 1023);
      wait_until(t + 8);

      apply_stimulus(3'b010);
      t = next_tick(cyc + 1);
      push_state(t, "restraight_1", FWD, FWD, 768, 1023);
      push_state(t + 4, "restraight_2", FWD, FWD, 1023, 1023);
      wait_until(t + 4);

      // sharp_turn_left: left wheel ramps down, flips, ramps up in reverse
      apply_stimulus(3'b100);
      t = next_tick(cyc + 1);
      for (int k = 0; k < 8; k++)
         push_state(t + 4 * k, "reversal", rev_dir[k], FWD, rev_duty[k], 1023);
      wait_until(t + 28);

      // stop issued so state_q updates on a non-tick edge
      wait_until(cyc + 1);
      apply_stimulus(3'b011);
      s = cyc + 1;
      push_state(s, "stop_latch", REV, FWD, 512, 1023);
      push_state(s + 1, "stop_applied", COAST, COAST, 0, 0);
      push_mov(s + 1, "stop_moving_lag", 1'b1);
      push_out(s + 2, "stop_out", 1'b0, 1'b0, 1'b0);
      t = next_tick(s + 1);
      push_state(t, "stop_on_tick", COAST, COAST, 0, 0);
      wait_until(t + 1);

      // invalid code 111 behaves like stop
      apply_stimulus(3'b010);
      t = next_tick(cyc + 1);
      push_state(t, "inv_pre_dir", FWD, FWD, 0, 0);
      push_state(t + 4, "inv_pre_ramp", FWD, FWD, 256, 256);
      wait_until(t + 4);
      apply_stimulus(3'b111);
      s = cyc + 1;
      push_state(s, "inv_latch", FWD, FWD, 256, 256);
      push_state(s + 1, "inv_stop", COAST, COAST, 0, 0);
      push_mov(s + 1, "inv_moving_lag", 1'b1);
      push_out(s + 2, "inv_out", 1'b0, 1'b0, 1'b0);
      wait_until(s + 2);

      // reset mid ramp-up at duty 512, then ramp restarts from zero
      apply_stimulus(3'b010);
      t = next_tick(cyc + 1);
      push_state(t, "pre_reset_dir", FWD, FWD, 0, 0);
      push_state(t + 4, "pre_reset_256", FWD, FWD, 256, 256);
      push_state(t + 8, "pre_reset_512", FWD, FWD, 512, 512);
      wait_until(t + 8);
      reset = 1'b1;
      s = cyc + 1;
      push_state(s, "reset_mid", COAST, COAST, 0, 0);
      push_out(s, "reset_mid_out", 1'b0, 1'b0, 1'b0);
      wait_until(s);
      reset = 1'b0;
      rel_edge = s;
      t = next_tick(cyc + 1);
      push_state(s + 3, "reset_no_early_tick", COAST, COAST, 0, 0);
      push_state(t, "post_reset_dir", FWD, FWD, 0, 0);
      push_state(t + 4, "post_reset_256", FWD, FWD, 256, 256);
      wait_until(t + 4);

      guard = 0;
      while (sb.size() > 0 && guard < 100) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/motor_drive_controller.md
# motor_drive_controller

Consumes the 3-bit steering command produced by the line-tracker decoder and drives the two DC-motor H-bridge channels (left and right). It registers the command, maps it to a per-motor target direction and duty, and slews each motor's duty with a soft-start/soft-stop ramp. Direction reversal is made safe by ramping the motor to zero before the direction pins change. The PWM outputs come from a free-running counter compared against the ramped duty.

## Interface
- PWM_BITS, 10: PWM counter/duty width; PWM period = 2^PWM_BITS cycles
- DUTY_FAST, 1023: duty for the outer/forward-fast wheel
- DUTY_SLOW, 512: duty for the inner wheel, and for the reversing wheel on sharp turns
- RAMP_DIV, 50000: cycles between ramp ticks (≥2)
- RAMP_STEP, 64: duty change per ramp tick (≥1)
- Reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- state  in  3  steering command: 000 turn_left, 001 turn_right, 010 go_straight, 011 stop, 100 sharp_turn_left, 101 sharp_turn_right; 110/111 treated as stop
- left_pwm  out  1  left motor enable PWM
- right_pwm  out  1  right motor enable PWM
- left_dir  out  2  left H-bridge {IN1,IN2}: 10 forward, 01 reverse, 00 coast
- right_dir  out  2  right H-bridge, same encoding
- moving  out  1  high when either motor's current duty ≠ 0

## Operation
- state_q <= state every cycle. All decoding uses state_q.
- Target (dir, duty) for each command, listed as left / right:
  - go_straight: fwd FAST / fwd FAST
  - turn_left: fwd SLOW / fwd FAST
  - turn_right: fwd FAST / fwd SLOW
  - sharp_turn_left: rev SLOW / fwd FAST
  - sharp_turn_right: fwd FAST / rev SLOW
  - stop or invalid: coast 0 / coast 0
- Stop override: while state_q decodes to stop, in every cycle (not gated by the tick), both current duties <= 0 and both dirs <= 00.
- Ramp tick: a prescaler counts 0..RAMP_DIV-1 and wraps; the tick is the cycle where prescaler == RAMP_DIV-1. The prescaler runs continuously, independent of state.
- On a tick, each motor updates independently, with the first matching rule applied:
  1. dir ≠ target dir and duty > 0: duty <= (duty > STEP) ? duty−STEP : 0. Dir is unchanged.
  2. dir ≠ target dir and duty == 0: dir <= target dir. Duty stays 0.
  3. duty < target: duty <= min(duty+STEP, target).
  4. duty > target: duty <= max(duty−STEP, target).
  5. Otherwise: hold.
- Arithmetic uses PWM_BITS+1 bits internally. Results are clamped to [0, 2^PWM_BITS−1] and never wrap.
- The direction pins never change while that motor's duty is nonzero.
- PWM generation: pwm_cnt increments every cycle and wraps from 2^PWM_BITS−1 to 0. x_pwm <= (pwm_cnt < duty_x).
  - Duty 0 gives constant low.
  - Duty 1023 is low for 1 cycle per 1024.
- moving <= (left_duty ≠ 0) | (right_duty ≠ 0), registered.

## Timing
- Reset values: state_q = 011, both duties 0, left_dir = right_dir = 00, left_pwm = right_pwm = 0, moving = 0, prescaler 0, pwm_cnt 0.
- Reset asserted mid-ramp forces all of the above on the next edge, overriding everything else.
- Command latency:
  - state changes before edge N; state_q updates at N.
  - Stop takes effect on duties and dirs at N+1.
  - PWM and moving outputs reflect the new duty at N+2.
- Non-stop commands act only on ramp ticks. The first tick after reset release is RAMP_DIV cycles after it.
- From rest (dir 00), a move command needs one tick to set dir, then ceil(target/STEP) ticks to reach the target duty.
- Reversal of a motor at duty D takes ceil(D/STEP) ticks down to 0, one tick to flip dir, then ramp-up ticks.
- A command change mid-ramp retargets at the next tick. There is no restart and no queued state.
- A tick coinciding with stop: stop wins.

## Test plan
Common parameters: PWM_BITS=10, RAMP_DIV=4, RAMP_STEP=256, DUTY_FAST=1023, DUTY_SLOW=512.

- **Reset then go_straight:** after reset release apply state=010.
  - Tick 1: both dirs become 10, duties stay 0.
  - Ticks 2–5: duties go 256, 512, 768, 1023 (clamped).
  - left_pwm is high 1023 of every 1024 cycles.
- **Steady turn_left:** from go_straight steady, apply 000. Next tick left duty = 767, the following tick 512. Right stays 1023 and both dirs stay 10.
- **Reversal:** from go_straight steady, apply 100.
  - Left duty goes 767, 511, 255, 0 over 4 ticks with left_dir held at 10.
  - Tick 5: left_dir = 01.
  - Ticks 6–7: left duty goes 256, 512.
  - left_dir never changes while left duty ≠ 0.
- **Stop override:** from any moving state apply 011 at a non-tick cycle. Duties are 0 and dirs 00 one cycle after state_q updates. pwm is low and moving = 0 the cycle after that.
- **Invalid code and mid-ramp reset:**
  - state=111 behaves exactly like 011.
  - Asserting reset during a ramp-up at duty 512 yields all outputs 0 and dirs 00 on the next edge.
  - After release with go_straight, the ramp restarts from duty 0.
